fetch_redirect_unit: RTL and testbench

- Produces the fetch PC and issues instruction-memory requests.
- Accepts branch-resolution redirects (taken target from the BEQ stage) and hands fetched instructions, with their PC, to decode through a valid/ready handshake.
- Allows one outstanding memory request.
- Sits at the front of the datapath; its out_pc is the pc the branch stage consumes and resolves.

---
 rtl/fetch_redirect_unit_pkg.sv | 21 ++
 rtl/fetch_out_reg.sv | 35 +++
 rtl/fetch_redirect_unit.sv | 113 +++++++++++
 tb/tb_fetch_redirect_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the fetch/redirect front end.
// Holds the fetch FSM encoding, the instruction size and the default reset PC.
package fetch_redirect_unit_pkg;

   localparam int unsigned PC_W_DEFAULT    = 32;
   localparam int unsigned INSTR_W_DEFAULT = 32;
   localparam int unsigned INSTR_BYTES     = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   // Force a fetch address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Single-entry valid/ready holding register between fetch and decode.
// A flush drops the held entry and blocks any load in the same cycle.
module fetch_out_reg #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [PC_W-1:0]    load_pc,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic               flush,
   input  logic               ready,
   output logic               valid,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         instr <= load_instr;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC generation with one outstanding imem request and branch redirects.
// Redirects override everything; a request already in flight is dropped via S_DROP.
module fetch_redirect_unit
   import fetch_redirect_unit_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEFAULT,
   parameter int unsigned     INSTR_W  = INSTR_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rsp_valid,
   input  logic [INSTR_W-1:0] mem_rsp_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               misalign_err
);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   req_pc_q, req_pc_d;
   logic              misalign_d;
   logic              load;
   logic [PC_W-1:0]   redirect_aligned;

   assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};
   assign mem_addr         = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         req_pc_q     <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         misalign_err <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      misalign_d = misalign_err;
      mem_req    = 1'b0;
      load       = 1'b0;

      case (state_q)
         S_FETCH: begin
            // Issue only when the output slot is empty or draining this cycle.
            mem_req = !rst && (!out_valid || out_ready);
            if (mem_req && mem_gnt) begin
               req_pc_d = pc_q;
               state_d  = redirect_valid ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               state_d = S_FETCH;
               if (!redirect_valid) begin
                  load = 1'b1;
                  pc_d = req_pc_q + PC_W'(INSTR_BYTES);
               end
            end else if (redirect_valid) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (mem_rsp_valid) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Redirect wins over any pc update computed above.
      if (redirect_valid) begin
         pc_d = redirect_aligned;
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end
   end

   fetch_out_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_pc    (req_pc_q),
      .load_instr (mem_rsp_data),
      .flush      (redirect_valid),
      .ready      (out_ready),
      .valid      (out_valid),
      .pc         (out_pc),
      .instr      (out_instr)
   );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench: the expected decode stream is a queue of consecutive word PCs
// restarted at every redirect target; memory data is a pure function of address.
module tb_fetch_redirect_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        misalign_err;

   fetch_redirect_unit #(
      .PC_W     (32),
      .INSTR_W  (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          idle     = 0;
   bit          mon_en   = 1'b0;
   bit          mis_m    = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] acc_addr[$];
   int          cons_cyc[$];

   bit          pend     = 1'b0;
   logic [31:0] pend_addr;
   int unsigned pend_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic restart_stream(input logic [31:0] start);
      exp_q.delete();
      exp_q.push_back(start);
   endtask

   // One clock of stimulus plus the memory model; inputs change only near negedge.
   task automatic drive_cycle(input bit rdy, input bit redir, input logic [31:0] tgt,
                              input int unsigned gnt_pct, input int unsigned max_lat);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (pend) begin
         if (pend_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr);
            pend          = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      out_ready      = rdy;
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (redir) begin
         if (mem_rsp_valid) mem_rsp_data = 32'hDEAD_BEEF;
         restart_stream(tgt & ~32'h3);
      end
      while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
      #1;
      mem_gnt = ($urandom_range(99) < gnt_pct);
      if (mem_req && mem_gnt) begin
         pend      = 1'b1;
         pend_addr = mem_addr;
         pend_cnt  = $urandom_range(max_lat);
         acc_addr.push_back(mem_addr);
      end
   endtask

   task automatic check_reset_state();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, RST_PC);
   endtask

   // Monitor: compares every accepted (non-flushed) handshake with the model stream.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (mon_en) begin
            chk("misalign_err", 32'(misalign_err), 32'(mis_m));
            if (redirect_valid && redirect_pc[1:0] != 2'b00) mis_m = 1'b1;
            if (mem_req && mem_addr[1:0] != 2'b00) chk("mem_addr_align", mem_addr, mem_addr & ~32'h3);
            if (out_valid && out_ready && !redirect_valid) begin
               if (exp_q.size() == 0) begin
                  chk("scoreboard_empty", 32'd0, 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_pc", out_pc, e);
                  chk("out_instr", out_instr, mem_word(e));
               end
               cons_cyc.push_back(cyc);
               idle = 0;
            end else if (redirect_valid) begin
               idle = 0;
            end else begin
               idle++;
               if (idle > 300) begin
                  chk("progress_timeout", 32'(idle), 32'd300);
                  idle = 0;
               end
            end
         end
      end
   end

   initial begin
      int k;
      logic [31:0] tgt;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check_reset_state();

      // Release reset: 1-cycle memory, always granting, decode always ready.
      restart_stream(RST_PC);
      @(negedge clk);
      rst = 1'b0;
      mis_m = 1'b0;
      mon_en = 1'b1;
      acc_addr.delete();
      cons_cyc.delete();
      for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b0, '0, 100, 0);
      chk("first_addr0", acc_addr[0], 32'h0);
      chk("first_addr1", acc_addr[1], 32'h4);
      chk("first_addr2", acc_addr[2], 32'h8);
      for (int i = 1; i < 4; i++) chk("issue_interval", 32'(cons_cyc[i] - cons_cyc[i-1]), 32'd2);

      // Decode stalls: entry must be held and no new fetch issued.
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, '0, 100, 0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, exp_q[0]);
      chk("stall_instr", out_instr, mem_word(exp_q[0]));
      chk("stall_no_req", 32'(mem_req), 32'd0);

      // Misaligned redirect, then a redirect to the last word to exercise wrap.
      drive_cycle(1'b1, 1'b1, 32'h0000_0042, 100, 0);
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, '0, 100, 0);
      acc_addr.delete();
      drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 100, 0);
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, '0, 100, 0);
      k = -1;
      for (int i = 0; i + 1 < acc_addr.size(); i++)
         if (k < 0 && acc_addr[i] == 32'hFFFF_FFFC) k = i;
      if (k < 0) chk("wrap_fetch_seen", 32'd0, 32'd1);
      else chk("wrap_next_addr", acc_addr[k+1], 32'h0);

      // Randomized traffic with redirects landing in every state.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(7))
            0:       tgt = 32'hFFFF_FFF8;
            1:       tgt = $urandom;
            default: tgt = $urandom & 32'h0000_0FFC;
         endcase
         drive_cycle($urandom_range(99) < 60, $urandom_range(11) == 0, tgt, 70, 3);
      end

      // Reset while a request is outstanding.
      k = 0;
      while (!pend && k < 50) begin
         drive_cycle(1'b1, 1'b0, '0, 100, 3);
         k++;
      end
      chk("wait_reached", 32'(pend), 32'd1);
      @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1; redirect_valid = 1'b0; mem_rsp_valid = 1'b0; mem_gnt = 1'b0; pend = 1'b0;
      @(negedge clk);
      #2;
      check_reset_state();
      rst = 1'b0;
      #1;
      chk("post_rst_req", 32'(mem_req), 32'd1);
      restart_stream(RST_PC);
      mis_m = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 300; i++)
         drive_cycle($urandom_range(99) < 70, $urandom_range(15) == 0,
                     $urandom & 32'h0000_00FF, 80, 2);
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, '0, 100, 0);
      chk("consumed_any", 32'(cons_cyc.size() > 20), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
